// File: rtl/lt24_pixel_bus_writer.sv
// rtl/lt24_pixel_bus_writer.sv - pixel handshake to ILI9341 8080-style LT24 bus writes
module lt24_pixel_bus_writer #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        pixelDropped,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    typedef enum logic [1:0] {IDLE, WRLO, WRHI} state_t;

    localparam logic [15:0] W_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] H_LAST = 16'(HEIGHT - 1);
    localparam logic [3:0]  LAST_IDX = 4'd11;

    state_t      state;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [15:0] d_q;
    logic [7:0]  prev_x;
    logic [8:0]  prev_y;
    logic        prev_valid;
    logic [7:0]  win_x;
    logic [3:0]  idx;
    logic [7:0]  timer;

    logic [8:0]  prev_x_inc;
    logic [9:0]  prev_y_inc;
    logic        in_range;
    logic        seq;
    logic [3:0]  start_idx;

    // {RS, bus value} for each position of the window/address/data sequence
    function automatic logic [16:0] bus_word(input logic [3:0] i, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] d);
        case (i)
            4'd0:    bus_word = {1'b0, 16'h002A};
            4'd1:    bus_word = {1'b1, 16'h0000};
            4'd2:    bus_word = {1'b1, 8'h00, x};
            4'd3:    bus_word = {1'b1, 8'h00, W_LAST[15:8]};
            4'd4:    bus_word = {1'b1, 8'h00, W_LAST[7:0]};
            4'd5:    bus_word = {1'b0, 16'h002B};
            4'd6:    bus_word = {1'b1, 15'h0000, y[8]};
            4'd7:    bus_word = {1'b1, 8'h00, y[7:0]};
            4'd8:    bus_word = {1'b1, 8'h00, H_LAST[15:8]};
            4'd9:    bus_word = {1'b1, 8'h00, H_LAST[7:0]};
            4'd10:   bus_word = {1'b0, 16'h002C};
            default: bus_word = {1'b1, d};
        endcase
    endfunction

    // Nine/ten-bit increments so column 255 or row 511 never wrap onto zero
    assign prev_x_inc = {1'b0, prev_x} + 9'd1;
    assign prev_y_inc = {1'b0, prev_y} + 10'd1;
    assign in_range   = (int'(xAddr) < WIDTH) && (int'(yAddr) < HEIGHT);
    assign seq = prev_valid &&
                 (({1'b0, xAddr} == prev_x_inc && yAddr == prev_y && int'(prev_x) < WIDTH - 1) ||
                  (int'(prev_x) == WIDTH - 1 && xAddr == win_x &&
                   {1'b0, yAddr} == prev_y_inc && int'(prev_y) < HEIGHT - 1));
    assign start_idx = seq ? LAST_IDX : 4'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pixelReady   <= 1'b0;
            pixelDropped <= 1'b0;
            LT24Wr_n     <= 1'b1;
            LT24Rd_n     <= 1'b1;
            LT24CS_n     <= 1'b1;
            LT24RS       <= 1'b0;
            LT24Data     <= 16'h0000;
            x_q          <= 8'h00;
            y_q          <= 9'h000;
            d_q          <= 16'h0000;
            prev_x       <= 8'h00;
            prev_y       <= 9'h000;
            prev_valid   <= 1'b0;
            win_x        <= 8'h00;
            idx          <= 4'd0;
            timer        <= 8'h00;
        end else begin
            pixelDropped <= 1'b0;
            LT24Rd_n     <= 1'b1;
            case (state)
                IDLE: begin
                    LT24CS_n   <= 1'b1;
                    LT24Wr_n   <= 1'b1;
                    pixelReady <= 1'b1;
                    if (pixelWrite && pixelReady) begin
                        if (!in_range) begin
                            pixelDropped <= 1'b1;
                            prev_valid   <= 1'b0;
                        end else begin
                            x_q        <= xAddr;
                            y_q        <= yAddr;
                            d_q        <= pixelData;
                            idx        <= start_idx;
                            timer      <= 8'h00;
                            pixelReady <= 1'b0;
                            LT24CS_n   <= 1'b0;
                            LT24Wr_n   <= 1'b0;
                            {LT24RS, LT24Data} <= bus_word(start_idx, xAddr, yAddr, pixelData);
                            if (!seq) win_x <= xAddr;
                            state      <= WRLO;
                        end
                    end
                end
                WRLO: begin
                    if (timer == 8'(WR_LOW - 1)) begin
                        timer    <= 8'h00;
                        LT24Wr_n <= 1'b1;
                        state    <= WRHI;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WRHI: begin
                    if (timer == 8'(WR_HIGH - 1)) begin
                        timer <= 8'h00;
                        if (idx == LAST_IDX) begin
                            prev_x     <= x_q;
                            prev_y     <= y_q;
                            prev_valid <= 1'b1;
                            LT24CS_n   <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx      <= idx + 4'd1;
                            LT24Wr_n <= 1'b0;
                            {LT24RS, LT24Data} <= bus_word(idx + 4'd1, x_q, y_q, d_q);
                            state    <= WRLO;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// tb/tb_lt24_pixel_bus_writer.sv - scoreboard bench for lt24_pixel_bus_writer
module tb_lt24_pixel_bus_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  xAddr = 8'h00;
    logic [8:0]  yAddr = 9'h000;
    logic [15:0] pixelData = 16'h0000;
    logic        pixelWrite = 1'b0;
    logic        pixelReady, pixelDropped, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
    logic [15:0] LT24Data;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    logic [16:0] exp_q[$];
    logic prev_wr = 1'b1;

    lt24_pixel_bus_writer dut (
        .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .pixelDropped(pixelDropped), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
        .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Data(LT24Data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {RS, data} for word i with the default 240x320 panel
    function automatic logic [16:0] exp_word(input int i, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] d);
        case (i)
            0:  return {1'b0, 16'h002A};
            1:  return {1'b1, 16'h0000};
            2:  return {1'b1, 8'h00, x};
            3:  return {1'b1, 16'h0000};
            4:  return {1'b1, 16'h00EF};
            5:  return {1'b0, 16'h002B};
            6:  return {1'b1, 15'h0000, y[8]};
            7:  return {1'b1, 8'h00, y[7:0]};
            8:  return {1'b1, 16'h0001};
            9:  return {1'b1, 16'h003F};
            10: return {1'b0, 16'h002C};
            default: return {1'b1, d};
        endcase
    endfunction

    // Monitor: every falling Wr_n edge is one bus word, checked against the queue
    always @(negedge clock) begin
        if (prev_wr && !LT24Wr_n) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", {15'h0, LT24RS, LT24Data}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("bus_word", {15'h0, LT24RS, LT24Data}, {15'h0, e});
                check("cs_during_word", {31'h0, LT24CS_n}, 32'h0);
            end
        end
        prev_wr = LT24Wr_n;
    end

    task automatic wait_ready();
        int n = 0;
        while (!pixelReady && n < 200) begin
            @(posedge clock); #1; n++;
        end
        if (!pixelReady) check("ready_timeout", {31'h0, pixelReady}, 32'h1);
    endtask

    task automatic write_px(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                            input bit full, input bit drop);
        int n;
        int p0;
        wait_ready();
        if (!drop) begin
            if (full) for (int i = 0; i < 12; i++) exp_q.push_back(exp_word(i, x, y, d));
            else exp_q.push_back(exp_word(11, x, y, d));
        end
        p0 = pulses;
        @(negedge clock);
        xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1;
        @(posedge clock); #1;
        if (drop) begin
            pixelWrite = 1'b0;
            check("drop_pulse", {31'h0, pixelDropped}, 32'h1);
            check("drop_ready", {31'h0, pixelReady}, 32'h1);
            @(posedge clock); #1;
            check("drop_pulse_end", {31'h0, pixelDropped}, 32'h0);
            repeat (3) @(posedge clock);
            #1 check("drop_no_bus", pulses - p0, 0);
        end else begin
            // Scramble inputs and keep requesting while busy; must not disturb the transfer
            xAddr = ~x; yAddr = ~y; pixelData = ~d;
            n = 0;
            do begin
                @(posedge clock); #1; n++;
            end while (!pixelReady && n < 100);
            pixelWrite = 1'b0;
            check(full ? "busy_full" : "busy_seq", n, full ? 49 : 5);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {31'h0, pixelReady}, 32'h0);
        check("rst_dropped", {31'h0, pixelDropped}, 32'h0);
        check("rst_wr", {31'h0, LT24Wr_n}, 32'h1);
        check("rst_rd", {31'h0, LT24Rd_n}, 32'h1);
        check("rst_cs", {31'h0, LT24CS_n}, 32'h1);
        check("rst_rs", {31'h0, LT24RS}, 32'h0);
        check("rst_data", {16'h0, LT24Data}, 32'h0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check("ready_after_reset", {31'h0, pixelReady}, 32'h1);

        write_px(8'd5, 9'd7, 16'hF920, 1, 0);
        write_px(8'd6, 9'd7, 16'h4DC4, 0, 0);

        // Row 0 stream, then row wrap onto winX=0
        for (int x = 0; x < 240; x++) write_px(8'(x), 9'd0, 16'(x * 3 + 1), x == 0, 0);
        write_px(8'd0, 9'd1, 16'h1234, 0, 0);

        // Window starting at x=10
        for (int x = 10; x < 240; x++) write_px(8'(x), 9'd0, 16'(16'hA000 + x), x == 10, 0);
        write_px(8'd10, 9'd1, 16'h5555, 0, 0);
        write_px(8'd0, 9'd2, 16'h6666, 1, 0);

        // Out-of-range drops clear continuity
        write_px(8'd240, 9'd0, 16'h7777, 0, 1);
        write_px(8'd0, 9'd320, 16'h8888, 0, 1);
        write_px(8'd1, 9'd0, 16'h9999, 1, 0);

        // Frame wrap is never sequential
        write_px(8'd239, 9'd319, 16'hBEEF, 1, 0);
        write_px(8'd0, 9'd0, 16'hCAFE, 1, 0);
        check("queue_drained", exp_q.size(), 0);

        // Reset during word 4 of a full transfer
        begin
            int p0;
            int n;
            wait_ready();
            p0 = pulses;
            for (int i = 0; i < 5; i++) exp_q.push_back(exp_word(i, 8'd100, 9'd200, 16'h0F0F));
            @(negedge clock);
            xAddr = 8'd100; yAddr = 9'd200; pixelData = 16'h0F0F; pixelWrite = 1'b1;
            @(posedge clock); #1 pixelWrite = 1'b0;
            n = 0;
            while (pulses < p0 + 5 && n < 100) begin
                @(posedge clock); #2; n++;
            end
            check("reached_word4", pulses - p0, 5);
            reset = 1'b1;
            @(posedge clock); #1;
            check("abort_wr", {31'h0, LT24Wr_n}, 32'h1);
            check("abort_cs", {31'h0, LT24CS_n}, 32'h1);
            check("abort_ready", {31'h0, pixelReady}, 32'h0);
            @(negedge clock); reset = 1'b0;
            @(posedge clock); #1;
            check("ready_after_abort", {31'h0, pixelReady}, 32'h1);
            check("abort_words", exp_q.size(), 0);
            write_px(8'd101, 9'd200, 16'h3C3C, 1, 0);
        end

        repeat (4) @(posedge clock);
        #1 check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lt24_pixel_bus_writer.md
Name: lt24_pixel_bus_writer

Overview:
- Responder end of the pixel write interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady) that the game logic drives.
- Accepts one pixel per handshake and converts it into ILI9341 8080-style bus writes on the LT24 pins.
- Sends a full window/address command sequence only when the new pixel is not the controller's auto-increment successor. Otherwise it sends a single data word.
- Panel power-up and init sequencing are not part of this block; they live elsewhere.

Parameters:
- WIDTH, 240, panel columns; x range is 0..WIDTH-1.
- HEIGHT, 320, panel rows; y range is 0..HEIGHT-1.
- WR_LOW, 2, clocks LT24Wr_n is held low per bus word (≥1).
- WR_HIGH, 2, clocks LT24Wr_n is held high after each word (≥1).

Ports:
- clock  in  1  single system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- xAddr  in  8  pixel column.
- yAddr  in  9  pixel row.
- pixelData  in  16  RGB565 colour.
- pixelWrite  in  1  request; qualified by pixelReady.
- pixelReady  out  1  high when a pixel can be accepted this cycle.
- pixelDropped  out  1  one-cycle pulse when an out-of-range pixel is accepted and discarded.
- LT24Wr_n  out  1  write strobe, active low.
- LT24Rd_n  out  1  tied high.
- LT24CS_n  out  1  chip select, active low.
- LT24RS  out  1  0 = command, 1 = data.
- LT24Data  out  16  bus data; command/parameter bytes on [7:0] with [15:8]=0.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high (`reset`).
- Reset values: pixelReady=0, pixelDropped=0, LT24Wr_n=1, LT24Rd_n=1, LT24CS_n=1, LT24RS=0, LT24Data=0, state=IDLE, prevValid=0, word index=0, timer=0.
- pixelReady rises in the first cycle after reset deasserts.
- Reset asserted mid-transfer aborts immediately. Outputs return to their reset values at the next edge; no partial word completes.
- Handshake: a pixel is accepted on an edge where pixelWrite && pixelReady. x, y and data are latched. pixelReady is 0 from the next cycle until the transfer ends.
- Range check: if x≥WIDTH or y≥HEIGHT, the pixel is accepted with no bus activity.
  - pixelDropped=1 for exactly one cycle.
  - prevValid is cleared.
  - pixelReady stays 1.
- Sequential test (SEQ): prevValid && one of the following holds:
  - x==prevX+1, y==prevY and prevX<WIDTH-1; or
  - prevX==WIDTH-1, x==winX, y==prevY+1 and prevY<HEIGHT-1.
- Word list (idx: RS, value):
  - 0: RS=0, 0x2A
  - 1: RS=1, 0x00
  - 2: RS=1, x
  - 3: RS=1, (WIDTH-1)>>8
  - 4: RS=1, (WIDTH-1)&0xFF
  - 5: RS=0, 0x2B
  - 6: RS=1, y[8]
  - 7: RS=1, y[7:0]
  - 8: RS=1, (HEIGHT-1)>>8
  - 9: RS=1, (HEIGHT-1)&0xFF
  - 10: RS=0, 0x2C
  - 11: RS=1, pixelData
- Start index: 11 if SEQ, else 0. A non-SEQ transfer also sets winX=x.
- State machine:
  - IDLE: CS_n=1, Wr_n=1, pixelReady=1. Goes to WRLO on an accepted in-range pixel.
  - WRLO: CS_n=0, Wr_n=0, RS and LT24Data driven from word[idx]. Held for WR_LOW cycles, then goes to WRHI.
  - WRHI: CS_n=0, Wr_n=1, RS and LT24Data unchanged (hold time). Held for WR_HIGH cycles.
    - If idx==11: go to IDLE, update prevX=x, prevY=y, prevValid=1.
    - Otherwise idx+1 and back to WRLO.
- Busy duration (accept edge to pixelReady=1):
  - SEQ pixel: 1 word, (WR_LOW+WR_HIGH) cycles plus 1.
  - Full pixel: 12 words, 12×(WR_LOW+WR_HIGH) cycles plus 1.
  - With defaults: 5 and 49 cycles.
- pixelWrite while busy is ignored. Data, x and y changes while busy do not affect the transfer in progress.
- Frame wrap: a pixel at (WIDTH-1, HEIGHT-1) followed by (0,0) is never SEQ and gets a full sequence.
- Widths: prevX+1 is computed at 9 bits so that 255 cannot alias to 0. y[8] is zero-extended to 8 bits for word 6.

Test Plan:
- Reset, then write pixel (5,7,0xF920) → exactly 12 Wr_n low pulses. Bus words in order: 2A,00,05,00,EF,2B,00,07,01,3F,2C,F920. RS pattern 0,1,1,1,1,0,1,1,1,1,0,1. pixelReady returns 49 cycles after accept.
- Then write (6,7,0x4DC4) → single data pulse, RS=1, LT24Data=0x4DC4. pixelReady returns after 5 cycles.
- Stream row 0 from x=0..239, then (0,1) → only the first pixel gets a full sequence; the other 240 are single words.
- Start at x=10, write through x=239, then (10,1) → single word (SEQ on winX). A following (0,2) → full sequence.
- Write (240,0) and (0,320) → pixelDropped pulses once each, no Wr_n activity, pixelReady stays 1. A following (1,0) → full sequence.
- Assert reset during word 4 of a full transfer → next edge: Wr_n=1, CS_n=1, pixelReady=0. After release, the first pixel gets a full sequence.
